// File: rtl/cim_tile_responder.sv
// Cycle-level model of one CIM crossbar tile: buffers an input vector, computes
// sat((in x W) >> out_shift) for every column, and serves one column per read.
module cim_tile_responder #(
   parameter int unsigned datatype_size = 8,
   parameter int unsigned xbar_size     = 512,
   parameter int unsigned out_shift     = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_wr_en,
   input  logic [$clog2(xbar_size)-1:0]  i_wr_addr,
   input  logic [datatype_size-1:0]      i_wr_data,
   input  logic                          i_w_we,
   input  logic [$clog2(xbar_size)-1:0]  i_w_row,
   input  logic [$clog2(xbar_size)-1:0]  i_w_col,
   input  logic [datatype_size-1:0]      i_w_data,
   input  logic                          i_start,
   output logic                          o_busy,
   input  logic [$clog2(xbar_size)-1:0]  i_rd_addr,
   output logic [datatype_size-1:0]      o_data
);

   localparam int unsigned AW    = $clog2(xbar_size);
   localparam int unsigned ACC_W = 2*datatype_size + AW;
   localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-datatype_size){1'b0}}, {datatype_size{1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_MAC, S_DONE} state_t;

   state_t                    r_state, w_next;
   logic [datatype_size-1:0]  r_in  [xbar_size];
   logic [datatype_size-1:0]  r_w   [xbar_size][xbar_size];
   logic [ACC_W-1:0]          r_acc [xbar_size];
   logic [datatype_size-1:0]  r_res [xbar_size];
   logic [AW-1:0]             r_row;
   logic [datatype_size-1:0]  r_data;
   logic                      w_idle;
   logic                      w_last_row;

   function automatic logic [datatype_size-1:0] f_sat(input logic [ACC_W-1:0] a);
      logic [ACC_W-1:0] s;
      s = a >> out_shift;
      if (s > SAT_MAX) return '1;
      return s[datatype_size-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_idle     = (r_state == S_IDLE);
      w_last_row = (r_row == AW'(xbar_size - 1));
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_CLEAR;
         S_CLEAR: w_next = S_MAC;
         S_MAC:   if (w_last_row) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign o_busy = ~w_idle;
   assign o_data = r_data;

   // Host-side writes are only honoured while idle; anything else is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < xbar_size; i++) r_in[i] <= '0;
      end else if (w_idle && i_wr_en) begin
         r_in[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (w_idle && i_w_we) r_w[i_w_row][i_w_col] <= i_w_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_row  <= '0;
         r_data <= '0;
         for (int unsigned c = 0; c < xbar_size; c++) begin
            r_acc[c] <= '0;
            r_res[c] <= '0;
         end
      end else begin
         r_data <= r_res[i_rd_addr];
         case (r_state)
            S_CLEAR: begin
               r_row <= '0;
               for (int unsigned c = 0; c < xbar_size; c++) r_acc[c] <= '0;
            end
            S_MAC: begin
               for (int unsigned c = 0; c < xbar_size; c++)
                  r_acc[c] <= r_acc[c] + ACC_W'(r_in[r_row]) * ACC_W'(r_w[r_row][c]);
               if (!w_last_row) r_row <= r_row + AW'(1);
            end
            S_DONE: begin
               for (int unsigned c = 0; c < xbar_size; c++) r_res[c] <= f_sat(r_acc[c]);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cim_tile_responder.sv
// Bench for cim_tile_responder: two 4x4 tiles (out_shift 0 and 8) share stimulus;
// read results are checked through a queue-based scoreboard.
module tb_cim_tile_responder;

   localparam int unsigned DW = 8;
   localparam int unsigned XS = 4;
   localparam int unsigned AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_wr_en;
   logic [AW-1:0] i_wr_addr;
   logic [DW-1:0] i_wr_data;
   logic          i_w_we;
   logic [AW-1:0] i_w_row;
   logic [AW-1:0] i_w_col;
   logic [DW-1:0] i_w_data;
   logic          i_start;
   logic [AW-1:0] i_rd_addr;
   logic          busy0, busy8;
   logic [DW-1:0] data0, data8;

   always #5 clk = ~clk;

   cim_tile_responder #(.datatype_size(DW), .xbar_size(XS), .out_shift(0)) dut0 (
      .clk(clk), .rst(rst),
      .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_w_we(i_w_we), .i_w_row(i_w_row), .i_w_col(i_w_col), .i_w_data(i_w_data),
      .i_start(i_start), .o_busy(busy0), .i_rd_addr(i_rd_addr), .o_data(data0)
   );

   cim_tile_responder #(.datatype_size(DW), .xbar_size(XS), .out_shift(8)) dut8 (
      .clk(clk), .rst(rst),
      .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
      .i_w_we(i_w_we), .i_w_row(i_w_row), .i_w_col(i_w_col), .i_w_data(i_w_data),
      .i_start(i_start), .o_busy(busy8), .i_rd_addr(i_rd_addr), .o_data(data8)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int a;
      int e0;
      int e8;
   } exp_t;

   exp_t sb[$];
   logic rd_v = 1'b0;
   int   cur0[XS];
   int   cur8[XS];

   always @(posedge clk) begin
      exp_t e;
      if (rd_v) begin
         #1;
         if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            e = sb.pop_front();
            chk($sformatf("rd_s0_col%0d", e.a), int'(data0), e.e0);
            chk($sformatf("rd_s8_col%0d", e.a), int'(data8), e.e8);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      int             mode;
      logic [3:0][7:0] vin;
      logic [3:0][7:0] e0;
      logic [3:0][7:0] e8;
      logic           gate;
   } vec_t;

   vec_t vt[6];

   function automatic logic [3:0][7:0] pk(input int a, input int b, input int c, input int d);
      logic [3:0][7:0] p;
      p[0] = a[7:0]; p[1] = b[7:0]; p[2] = c[7:0]; p[3] = d[7:0];
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
      i_w_we = 1'b0; i_w_row = '0; i_w_col = '0; i_w_data = '0;
      i_start = 1'b0; i_rd_addr = '0;
   endtask

   task automatic read_all();
      for (int a = 0; a < XS; a++) begin
         i_rd_addr = a[AW-1:0];
         rd_v = 1'b1;
         sb.push_back('{a, cur0[a], cur8[a]});
         tick();
      end
      rd_v = 1'b0;
   endtask

   // Weight writes for all 16 cells; input rows 0..2 are written alongside.
   task automatic load(input int mode, input logic [3:0][7:0] vin);
      for (int r = 0; r < XS; r++) begin
         for (int c = 0; c < XS; c++) begin
            i_w_we  = 1'b1;
            i_w_row = r[AW-1:0];
            i_w_col = c[AW-1:0];
            case (mode)
               0:       i_w_data = (r == c) ? 8'd1 : 8'd0;
               1:       i_w_data = 8'd255;
               2:       i_w_data = 8'd1;
               default: i_w_data = 8'(c + 1);
            endcase
            if (r == 0 && c < XS - 1) begin
               i_wr_en   = 1'b1;
               i_wr_addr = c[AW-1:0];
               i_wr_data = vin[c];
            end else begin
               i_wr_en = 1'b0;
            end
            tick();
         end
      end
      i_w_we  = 1'b0;
      i_wr_en = 1'b0;
   endtask

   // Row 3 write coincides with start; reads during busy expect the previous results.
   task automatic start_and_wait(input logic [7:0] last_in, input logic gate, output int cyc);
      int n;
      int a;
      i_wr_en = 1'b1; i_wr_addr = 2'd3; i_wr_data = last_in; i_start = 1'b1;
      tick();
      i_wr_en = 1'b0; i_start = 1'b0;
      chk("busy_after_start", int'(busy0), 1);
      n = 0;
      while (busy0 && n < 100) begin
         if (gate && n == 2) begin
            i_wr_en = 1'b1; i_wr_addr = 2'd0; i_wr_data = 8'd9;
            i_w_we = 1'b1; i_w_row = 2'd0; i_w_col = 2'd0; i_w_data = 8'd77;
            i_start = 1'b1;
         end else begin
            i_wr_en = 1'b0; i_w_we = 1'b0; i_start = 1'b0;
         end
         a = n % XS;
         i_rd_addr = a[AW-1:0];
         rd_v = 1'b1;
         sb.push_back('{a, cur0[a], cur8[a]});
         tick();
         n++;
      end
      rd_v = 1'b0;
      i_wr_en = 1'b0; i_w_we = 1'b0; i_start = 1'b0;
      cyc = n;
   endtask

   initial begin
      int cyc;
      for (int a = 0; a < XS; a++) begin
         cur0[a] = 0;
         cur8[a] = 0;
      end

      vt[0] = '{mode: 0, vin: pk(1,2,3,4),         e0: pk(1,2,3,4),         e8: pk(0,0,0,0),         gate: 1'b0};
      vt[1] = '{mode: 1, vin: pk(255,255,255,255), e0: pk(255,255,255,255), e8: pk(255,255,255,255), gate: 1'b0};
      vt[2] = '{mode: 2, vin: pk(255,255,255,255), e0: pk(255,255,255,255), e8: pk(3,3,3,3),         gate: 1'b0};
      vt[3] = '{mode: 3, vin: pk(1,2,3,4),         e0: pk(10,20,30,40),     e8: pk(0,0,0,0),         gate: 1'b0};
      vt[4] = '{mode: 2, vin: pk(200,200,200,0),   e0: pk(255,255,255,255), e8: pk(2,2,2,2),         gate: 1'b0};
      vt[5] = '{mode: 0, vin: pk(1,2,3,4),         e0: pk(1,2,3,4),         e8: pk(0,0,0,0),         gate: 1'b1};

      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_busy0", int'(busy0), 0);
      chk("rst_busy8", int'(busy8), 0);
      chk("rst_data0", int'(data0), 0);
      chk("rst_data8", int'(data8), 0);
      rst = 1'b0;
      read_all();

      for (int v = 0; v < 6; v++) begin
         load(vt[v].mode, vt[v].vin);
         start_and_wait(vt[v].vin[3], vt[v].gate, cyc);
         chk($sformatf("busy_len_v%0d", v), cyc, XS + 2);
         for (int a = 0; a < XS; a++) begin
            cur0[a] = int'(vt[v].e0[a]);
            cur8[a] = int'(vt[v].e8[a]);
         end
         read_all();
         chk($sformatf("one_window_v%0d", v), int'(busy0), 0);
      end

      // Recompute without reloading: a leaked gated write to in[0] or W[0][0] shows up here.
      start_and_wait(8'd4, 1'b0, cyc);
      chk("busy_len_rerun", cyc, XS + 2);
      read_all();

      // Reset mid-MAC abandons the compute and clears in/res/o_data.
      i_rd_addr = 2'd3;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      tick();
      chk("busy_mid_mac", int'(busy0), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_busy", int'(busy0), 0);
      chk("rst_mid_data0", int'(data0), 0);
      chk("rst_mid_data8", int'(data8), 0);
      for (int a = 0; a < XS; a++) begin
         cur0[a] = 0;
         cur8[a] = 0;
      end
      read_all();

      // Input buffer was cleared: identity weights with zeroed inputs give all zeros.
      start_and_wait(8'd0, 1'b0, cyc);
      chk("busy_len_after_rst", cyc, XS + 2);
      read_all();

      load(3, pk(1,2,3,4));
      start_and_wait(8'd4, 1'b0, cyc);
      chk("busy_len_fresh", cyc, XS + 2);
      cur0[0] = 10; cur0[1] = 20; cur0[2] = 30; cur0[3] = 40;
      read_all();

      tick();
      tick();
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
